// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: target adder, condition evaluation, prediction check,
// multi-cycle flush generation and a direct-mapped 2-bit branch history table.
module branch_resolve_unit #(
    parameter int PC_WIDE      = 7,
    parameter int OFFSET_SHIFT = 0,
    parameter int BHT_DEPTH    = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               valid_in,
    input  logic [2:0]         br_op,
    input  logic [PC_WIDE-1:0] pc_next,
    input  logic [31:0]        imm,
    input  logic [31:0]        rs_data,
    input  logic [31:0]        rt_data,
    input  logic               pred_taken_in,
    input  logic [PC_WIDE-1:0] lookup_pc,
    output logic               pred_taken,
    output logic [PC_WIDE-1:0] branch_pc,
    output logic               taken,
    output logic               mispredict,
    output logic [PC_WIDE-1:0] redirect_pc,
    output logic               flush,
    output logic [15:0]        mispredict_count
);

    localparam int         IDX        = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_BLEZ = 3'b011;
    localparam logic [2:0] OP_BGTZ = 3'b100;
    localparam logic [2:0] OP_BLTZ = 3'b101;
    localparam logic [2:0] OP_BGEZ = 3'b110;
    localparam logic [2:0] OP_ALWS = 3'b111;

    function automatic logic eval_cond(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic res;
        case (op)
            OP_NONE: res = 1'b0;
            OP_BEQ:  res = (a == b);
            OP_BNE:  res = (a != b);
            OP_BLEZ: res = a[31] | (a == 32'd0);
            OP_BGTZ: res = ~a[31] & (a != 32'd0);
            OP_BLTZ: res = a[31];
            OP_BGEZ: res = ~a[31];
            OP_ALWS: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end else begin
            res = (ctr == 2'b00) ? ctr : ctr - 2'd1;
        end
        return res;
    endfunction

    logic [1:0]         bht_q [BHT_DEPTH];
    logic [PC_WIDE-1:0] branch_pc_q, branch_pc_d;
    logic [PC_WIDE-1:0] redirect_pc_q, redirect_pc_d;
    logic               taken_q, taken_d;
    logic               mispredict_q, mispredict_d;
    logic               flush_q, flush_d;
    logic [3:0]         flush_cnt_q, flush_cnt_d;
    logic [15:0]        mis_cnt_q, mis_cnt_d;

    logic               acc_s;
    logic               cond_s;
    logic               mis_s;
    logic               bht_wr_s;
    logic [31:0]        imm_sh_s;
    logic [PC_WIDE-1:0] tgt_s;
    logic [IDX-1:0]     upd_idx_s;
    logic [1:0]         bht_new_s;
    logic               unused_s;

    // Squashed instructions (flush high) and stalled cycles are never accepted.
    assign acc_s     = valid_in & ~stall & ~flush_q;
    assign cond_s    = eval_cond(br_op, rs_data, rt_data);
    assign mis_s     = cond_s ^ pred_taken_in;
    assign imm_sh_s  = imm << OFFSET_SHIFT;
    assign tgt_s     = pc_next + imm_sh_s[PC_WIDE-1:0];
    assign upd_idx_s = pc_next[IDX-1:0];
    assign bht_wr_s  = acc_s & (br_op != OP_NONE);
    assign bht_new_s = sat_update(bht_q[upd_idx_s], cond_s);
    assign unused_s  = ^{imm_sh_s, lookup_pc};

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    assign pred_taken       = bht_q[lookup_pc[IDX-1:0]][1];
    assign branch_pc        = branch_pc_q;
    assign taken            = taken_q;
    assign mispredict       = mispredict_q;
    assign redirect_pc      = redirect_pc_q;
    assign flush            = flush_q;
    assign mispredict_count = mis_cnt_q;

    // Next-state for result registers, flush sequencer and mispredict counter.
    always_comb begin
        branch_pc_d   = branch_pc_q;
        redirect_pc_d = redirect_pc_q;
        taken_d       = taken_q;
        mispredict_d  = mispredict_q;
        flush_d       = flush_q;
        flush_cnt_d   = flush_cnt_q;
        mis_cnt_d     = mis_cnt_q;
        if (!stall) begin
            if (acc_s) begin
                branch_pc_d   = tgt_s;
                taken_d       = cond_s;
                redirect_pc_d = cond_s ? tgt_s : pc_next;
                mispredict_d  = mis_s;
            end else begin
                taken_d      = 1'b0;
                mispredict_d = 1'b0;
            end
            if (acc_s && mis_s) begin
                flush_d     = 1'b1;
                flush_cnt_d = FLUSH_LOAD;
                if (mis_cnt_q != 16'hFFFF) begin
                    mis_cnt_d = mis_cnt_q + 16'd1;
                end else begin
                    mis_cnt_d = mis_cnt_q;
                end
            end else if (flush_q) begin
                if (flush_cnt_q == 4'd0) begin
                    flush_d = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end else begin
                flush_d = 1'b0;
            end
        end else begin
            flush_d = flush_q;
        end
    end

    // Result and control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_pc_q   <= '0;
            redirect_pc_q <= '0;
            taken_q       <= 1'b0;
            mispredict_q  <= 1'b0;
            flush_q       <= 1'b0;
            flush_cnt_q   <= 4'd0;
            mis_cnt_q     <= 16'd0;
        end else begin
            branch_pc_q   <= branch_pc_d;
            redirect_pc_q <= redirect_pc_d;
            taken_q       <= taken_d;
            mispredict_q  <= mispredict_d;
            flush_q       <= flush_d;
            flush_cnt_q   <= flush_cnt_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

    // Branch history table: weakly not-taken after reset, saturating update on resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (bht_wr_s) begin
            bht_q[upd_idx_s] <= bht_new_s;
        end
    end

endmodule
